// File: rtl/phase_seq.sv
// Instruction phase sequencer: latches an instruction word, then walks the REG/MOD/RAD
// strobes, an optional memory wait, and EXEC/WBK, each as a one-cycle Moore pulse.
module phase_seq #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IR_VALID,
    input  logic [15:0]      IR_IN,
    input  logic             MEM_RDY,
    input  logic             HALT_REQ,
    output logic             IR_ACK,
    output logic [15:0]      IR,
    output logic             REG,
    output logic             MOD,
    output logic             RAD,
    output logic             MEM_WAIT,
    output logic             EXEC,
    output logic             WBK,
    output logic             HALTED,
    output logic             ERR,
    output logic [CNT_W-1:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        IDLE,
        S_REG,
        S_MOD,
        S_RAD,
        S_WAIT,
        S_EXEC,
        S_WB,
        HALT
    } state_t;

    localparam logic [7:0]       WAIT_LIM = 8'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       short_form;
    logic       timeout;

    assign accept     = (state == IDLE) && IR_VALID && !HALT_REQ;
    // Register-immediate opcode skips the mode-driven phases entirely.
    assign short_form = (IR[15:12] == 4'b1011) || (IR[7:6] == 2'b00);
    assign timeout    = (state == S_WAIT) && !MEM_RDY && (wait_cnt == WAIT_LIM);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (HALT_REQ) begin
                    state_next = HALT;
                end else if (IR_VALID) begin
                    state_next = S_REG;
                end
            end
            S_REG: begin
                if (short_form) begin
                    state_next = S_EXEC;
                end else if (IR[6]) begin
                    state_next = S_MOD;
                end else begin
                    state_next = S_RAD;
                end
            end
            S_MOD:  state_next = IR[7] ? S_RAD : S_EXEC;
            S_RAD:  state_next = S_WAIT;
            S_WAIT: begin
                if (MEM_RDY) begin
                    state_next = S_EXEC;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            S_EXEC: state_next = S_WB;
            S_WB:   state_next = IDLE;
            HALT: begin
                if (!HALT_REQ) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Wait counter idles at zero outside S_WAIT, so it is already cleared on entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            IR        <= 16'h0000;
            wait_cnt  <= 8'd0;
            ERR       <= 1'b0;
            INSTR_CNT <= '0;
        end else begin
            if (accept) begin
                IR <= IR_IN;
            end
            if (state != S_WAIT) begin
                wait_cnt <= 8'd0;
            end else if (!MEM_RDY && !timeout) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (timeout) begin
                ERR <= 1'b1;
            end
            if (state == S_WB) begin
                INSTR_CNT <= INSTR_CNT + CNT_ONE;
            end
        end
    end

    assign IR_ACK   = (state == S_REG);
    assign REG      = (state == S_REG);
    assign MOD      = (state == S_MOD);
    assign RAD      = (state == S_RAD);
    assign MEM_WAIT = (state == S_WAIT);
    assign EXEC     = (state == S_EXEC);
    assign WBK      = (state == S_WB);
    assign HALTED   = (state == HALT);

endmodule

// File: tb/tb_phase_seq.sv
// Bench for phase_seq: per-instruction phase sequences are derived from the opcode/mode
// rules and a memory-ready delay, then compared cycle by cycle against the DUT.
`timescale 1ns/1ps
module tb_phase_seq;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;
    localparam int CNT_MOD  = 1 << CNT_W;

    localparam logic [7:0] C_REG  = 8'hC0;
    localparam logic [7:0] C_MOD  = 8'h20;
    localparam logic [7:0] C_RAD  = 8'h10;
    localparam logic [7:0] C_WAIT = 8'h08;
    localparam logic [7:0] C_EXEC = 8'h04;
    localparam logic [7:0] C_WBK  = 8'h02;
    localparam logic [7:0] C_HALT = 8'h01;

    logic             CLK = 1'b0;
    logic             RST;
    logic             IR_VALID;
    logic [15:0]      IR_IN;
    logic             MEM_RDY;
    logic             HALT_REQ;
    logic             IR_ACK;
    logic [15:0]      IR;
    logic             REG;
    logic             MOD;
    logic             RAD;
    logic             MEM_WAIT;
    logic             EXEC;
    logic             WBK;
    logic             HALTED;
    logic             ERR;
    logic [CNT_W-1:0] INSTR_CNT;
    logic [7:0]       strobes;

    phase_seq #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .IR_VALID(IR_VALID), .IR_IN(IR_IN), .MEM_RDY(MEM_RDY),
        .HALT_REQ(HALT_REQ), .IR_ACK(IR_ACK), .IR(IR), .REG(REG), .MOD(MOD), .RAD(RAD),
        .MEM_WAIT(MEM_WAIT), .EXEC(EXEC), .WBK(WBK), .HALTED(HALTED), .ERR(ERR),
        .INSTR_CNT(INSTR_CNT)
    );

    assign strobes = {IR_ACK, REG, MOD, RAD, MEM_WAIT, EXEC, WBK, HALTED};

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] code;
        bit         rdy;
        bit         inc;
        bit         err;
    } step_t;

    typedef struct {
        logic [15:0] word;
        int          delay;
        int          exp_len;
        int          exp_done;
    } vec_t;

    step_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    bit          exp_err = 1'b0;
    logic [15:0] last_ir = 16'h0000;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [15:0] word, input bit rdy, input bit halt);
        IR_VALID = valid;
        IR_IN    = word;
        MEM_RDY  = rdy;
        HALT_REQ = halt;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_strobes"}, 32'(strobes), 32'(8'h00));
        checkOutput({name, "_ir"}, 32'(IR), 32'(last_ir));
        checkOutput({name, "_cnt"}, 32'(INSTR_CNT), 32'(exp_cnt));
        checkOutput({name, "_err"}, 32'(ERR), 32'(exp_err));
    endtask

    // Expected strobe per cycle from the accept edge: MEM_RDY first seen in wait cycle d.
    function automatic void buildExpected(input logic [15:0] word, input int d);
        bit aborted = 1'b0;
        exp_q.delete();
        exp_q.push_back('{C_REG, 1'($urandom), 1'b0, 1'b0});
        if (word[15:12] != 4'b1011 && word[7:6] != 2'b00) begin
            if (word[6]) exp_q.push_back('{C_MOD, 1'($urandom), 1'b0, 1'b0});
            if (word[7]) begin
                exp_q.push_back('{C_RAD, 1'($urandom), 1'b0, 1'b0});
                for (int j = 0; j <= WAIT_MAX; j++) begin
                    if (j >= d) begin
                        exp_q.push_back('{C_WAIT, 1'b1, 1'b0, 1'b0});
                        break;
                    end
                    exp_q.push_back('{C_WAIT, 1'b0, 1'b0, j == WAIT_MAX});
                    if (j == WAIT_MAX) aborted = 1'b1;
                end
            end
        end
        if (!aborted) begin
            exp_q.push_back('{C_EXEC, 1'($urandom), 1'b0, 1'b0});
            exp_q.push_back('{C_WBK, 1'($urandom), 1'b1, 1'b0});
        end
    endfunction

    task automatic runInstr(input logic [15:0] word, input int d, input bit halt_busy,
                            output int obs_len, output int obs_wbk);
        buildExpected(word, d);
        obs_len = 0;
        obs_wbk = 0;
        applyStimulus(1'b1, word, 1'($urandom), 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) applyStimulus(1'($urandom), 16'($urandom), exp_q[i-1].rdy, halt_busy);
            checkOutput("strobes", 32'(strobes), 32'(exp_q[i].code));
            checkOutput("ir_hold", 32'(IR), 32'(word));
            checkOutput("instr_cnt", 32'(INSTR_CNT), 32'(exp_cnt));
            checkOutput("err", 32'(ERR), 32'(exp_err));
            if (strobes != 8'h00) obs_len++;
            if (WBK) obs_wbk++;
            if (exp_q[i].inc) exp_cnt = (exp_cnt + 1) % CNT_MOD;
            if (exp_q[i].err) exp_err = 1'b1;
        end
        applyStimulus(1'($urandom), 16'($urandom), exp_q[exp_q.size()-1].rdy, halt_busy);
        last_ir = word;
        checkIdle("after_instr");
        IR_VALID = 1'b0;
        HALT_REQ = 1'b0;
    endtask

    initial begin
        vec_t vecs[12];
        int   len;
        int   done;

        vecs[0]  = '{16'h0000, 0, 3, 1};
        vecs[1]  = '{16'hB3C0, 0, 3, 1};
        vecs[2]  = '{16'h0040, 0, 4, 1};
        vecs[3]  = '{16'h00C0, 2, 8, 1};
        vecs[4]  = '{16'h0080, 0, 5, 1};
        vecs[5]  = '{16'h0080, 15, 20, 1};
        vecs[6]  = '{16'h0080, 14, 19, 1};
        vecs[7]  = '{16'h70BF, 1, 6, 1};
        vecs[8]  = '{16'hB080, 99, 3, 1};
        vecs[9]  = '{16'h0080, 99, 18, 0};
        vecs[10] = '{16'h0000, 0, 3, 1};
        vecs[11] = '{16'hF0C0, 3, 9, 1};

        RST = 1'b1;
        applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
        checkIdle("reset");
        RST = 1'b0;

        foreach (vecs[v]) begin
            runInstr(vecs[v].word, vecs[v].delay, 1'b0, len, done);
            checkOutput($sformatf("vec%0d_len", v), 32'(len), 32'(vecs[v].exp_len));
            checkOutput($sformatf("vec%0d_wbk", v), 32'(done), 32'(vecs[v].exp_done));
        end

        // HALT_REQ beats IR_VALID in IDLE; accept resumes once it drops.
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1);
        checkOutput("halt_enter", 32'(strobes), 32'(C_HALT));
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1);
        checkOutput("halt_hold", 32'(strobes), 32'(C_HALT));
        checkOutput("halt_ir", 32'(IR), 32'(last_ir));
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        checkIdle("halt_exit");
        runInstr(16'h1234, 0, 1'b0, len, done);
        checkOutput("halt_resume_wbk", 32'(done), 32'd1);

        // Reset mid-wait drops the instruction and clears ERR and the counter.
        applyStimulus(1'b1, 16'h0080, 1'b0, 1'b0);
        checkOutput("rw_reg", 32'(strobes), 32'(C_REG));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("rw_rad", 32'(strobes), 32'(C_RAD));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("rw_wait", 32'(strobes), 32'(C_WAIT));
        RST = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        RST = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
        last_ir = 16'h0000;
        checkIdle("rw_reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
            checkIdle("rw_after");
        end

        // Sixteen completions wrap the 4-bit counter back to zero.
        for (int i = 0; i < CNT_MOD; i++) begin
            runInstr(16'($urandom) & 16'hFF3F, 0, 1'b0, len, done);
        end
        checkOutput("cnt_wrap", 32'(INSTR_CNT), 32'd0);

        for (int n = 0; n < 60; n++) begin
            runInstr(16'($urandom), int'($urandom_range(0, 18)), 1'($urandom), len, done);
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, 16'($urandom), 1'($urandom), 1'b0);
                checkIdle("gap");
            end
            if ($urandom_range(0, 5) == 0) begin
                applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), 1'b1);
                checkOutput("rand_halt", 32'(strobes), 32'(C_HALT));
                applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), 1'b0);
                checkIdle("rand_unhalt");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
